// File: rtl/countdown_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_display_driver
//  Description : Converts the countdown counter's binary value to three BCD
//                digits with a sequential shift-add-3 (double-dabble)
//                converter, then time-multiplexes the digits onto a common
//                7-segment bus with leading-zero blanking. Also provides a
//                registered zero flag for timer-expired logic.
//  Ports       : clock     - system clock, rising edge
//                reset     - synchronous active-high reset
//                value     - binary count (unsigned, WIDTH bits)
//                hundreds  - BCD hundreds digit of last completed conversion
//                tens      - BCD tens digit
//                ones      - BCD ones digit
//                conv_done - 1-cycle pulse when the digits update
//                zero      - 1 when the last completed conversion was 0
//                seg       - segment bus {g,f,e,d,c,b,a}
//                an        - one-hot digit select (an[0]=ones .. an[2]=hundreds)
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_display_driver #(
   parameter int WIDTH          = 9,
   parameter int REFRESH_DIV    = 1000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] value,
   output logic [3:0]       hundreds,
   output logic [3:0]       tens,
   output logic [3:0]       ones,
   output logic             conv_done,
   output logic             zero,
   output logic [6:0]       seg,
   output logic [2:0]       an
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_SHIFT = 2'd1;
   localparam logic [1:0] c_LOAD  = 2'd2;

   localparam int               c_CNT_W    = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

   // A divider of 1 still needs a 1-bit register that sits at its terminal count
   localparam int               c_DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic               w_capture;
   logic               w_shift;
   logic               w_load;

   logic [WIDTH-1:0]   r_shreg;
   logic [11:0]        r_bcd;
   logic [11:0]        w_bcd_adj;
   logic [c_CNT_W-1:0] r_bit_cnt;

   logic [c_DIV_W-1:0] r_div;
   logic [1:0]         r_idx;

   logic [3:0]         w_digit;
   logic               w_blank;
   logic [6:0]         w_seg_ah;
   logic [2:0]         w_an_ah;

   // ------------------------------------------------------------------------
   // Converter FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Converter FSM: next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  w_next_state = c_SHIFT;
         c_SHIFT: if (r_bit_cnt == c_LAST_BIT) w_next_state = c_LOAD;
         c_LOAD:  w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   // Converter FSM: datapath controls
   always_comb begin
      w_capture = 1'b0;
      w_shift   = 1'b0;
      w_load    = 1'b0;
      case (r_state)
         c_IDLE:  w_capture = 1'b1;
         c_SHIFT: w_shift   = 1'b1;
         c_LOAD:  w_load    = 1'b1;
         default: w_capture = 1'b0;
      endcase
   end

   // Add-3 correction applied to each nibble before it is doubled, so that a
   // nibble of 5..9 carries into the next decade after the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int n = 0; n < 3; n++) begin
         if (r_bcd[n*4 +: 4] >= 4'd5) begin
            w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Converter datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_shreg   <= '0;
         r_bcd     <= '0;
         r_bit_cnt <= '0;
         hundreds  <= 4'd0;
         tens      <= 4'd0;
         ones      <= 4'd0;
         conv_done <= 1'b0;
         zero      <= 1'b1;
      end else begin
         conv_done <= w_load;
         if (w_capture) begin
            r_shreg   <= value;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
         end
         if (w_shift) begin
            r_bcd     <= {w_bcd_adj[10:0], r_shreg[WIDTH-1]};
            r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_load) begin
            hundreds <= r_bcd[11:8];
            tens     <= r_bcd[7:4];
            ones     <= r_bcd[3:0];
            zero     <= (r_bcd == 12'd0);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Refresh divider and digit index (0=ones, 1=tens, 2=hundreds)
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_div <= '0;
         r_idx <= 2'd0;
      end else if (r_div == c_DIV_LAST) begin
         r_div <= '0;
         r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Digit select, leading-zero blanking and 7-segment decode (active-high)
   // ------------------------------------------------------------------------
   always_comb begin
      w_digit = ones;
      w_blank = 1'b0;
      case (r_idx)
         2'd2: begin
            w_digit = hundreds;
            w_blank = (hundreds == 4'd0);
         end
         2'd1: begin
            w_digit = tens;
            w_blank = (hundreds == 4'd0) && (tens == 4'd0);
         end
         default: begin
            w_digit = ones;
            w_blank = 1'b0;
         end
      endcase

      case (w_digit)
         4'd0:    w_seg_ah = 7'h3F;
         4'd1:    w_seg_ah = 7'h06;
         4'd2:    w_seg_ah = 7'h5B;
         4'd3:    w_seg_ah = 7'h4F;
         4'd4:    w_seg_ah = 7'h66;
         4'd5:    w_seg_ah = 7'h6D;
         4'd6:    w_seg_ah = 7'h7D;
         4'd7:    w_seg_ah = 7'h07;
         4'd8:    w_seg_ah = 7'h7F;
         4'd9:    w_seg_ah = 7'h6F;
         default: w_seg_ah = 7'h00;
      endcase
      if (w_blank) begin
         w_seg_ah = 7'h00;
      end

      w_an_ah = 3'b001 << r_idx;
   end

   generate
      if (SEG_ACTIVE_LOW != 0) begin : g_active_low
         assign seg = ~w_seg_ah;
         assign an  = ~w_an_ah;
      end else begin : g_active_high
         assign seg = w_seg_ah;
         assign an  = w_an_ah;
      end
   endgenerate

endmodule
`default_nettype wire
